// File: rtl/nmi_source_ctrl_if.sv
// Handshake bundle between the NMI source controller and its surroundings:
// peripheral request lines, mask, CPU acknowledge and the controller's status.
interface nmi_source_ctrl_if;
  logic [3:0] irq;
  logic [3:0] irq_mask;
  logic       nmi_ack;
  logic       clr_err;
  logic       nmi;
  logic [1:0] nmi_id;
  logic [3:0] pending;
  logic       active;
  logic       timeout_err;

  modport master (output irq, irq_mask, nmi_ack, clr_err,
                  input  nmi, nmi_id, pending, active, timeout_err);
  modport slave  (input  irq, irq_mask, nmi_ack, clr_err,
                  output nmi, nmi_id, pending, active, timeout_err);
endinterface

// File: rtl/nmi_source_ctrl.sv
// NMI source controller: latches four peripheral request edges as pending,
// picks one, pulses nmi with a stable nmi_id and follows nmi_ack through
// acceptance (low) and ISR return (high) before issuing the next request.
// Optional: define NMI_SRC_RR_PRIORITY_EN for round-robin selection instead
// of fixed lowest-index priority.
// PULSE_CYCLES >= 2, GAP_CYCLES >= 1, ACK_TIMEOUT > PULSE_CYCLES.
module nmi_source_ctrl #(
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 64,
  parameter int GAP_CYCLES   = 2
) (
  input  logic               clock,
  input  logic               reset,
  nmi_source_ctrl_if.slave   bus
);
  localparam int PCW = $clog2(PULSE_CYCLES);
  localparam int TCW = $clog2(ACK_TIMEOUT + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ASSERT, WAIT_ACCEPT, IN_SERVICE, GAP} state_t;

  state_t         state_q, state_d;
  logic [3:0]     irq_q, pend_q, pend_d, clr_vec, rise, elig;
  logic           ack_m, ack_s;
  logic           nmi_q, nmi_d, act_q, act_d, terr_q, terr_d, acc_q, acc_d, set_to;
  logic [1:0]     id_q, id_d, win_id;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic [GCW-1:0] gcnt_q, gcnt_d;

  assign rise = bus.irq & ~irq_q;
  assign elig = pend_q & bus.irq_mask;

`ifdef NMI_SRC_RR_PRIORITY_EN
  logic [1:0] last_q, last_d, idx;
  logic       found;

  // Round-robin pick: search starts one past the last line that entered service
  always_comb begin
    win_id = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = last_q + 2'(k) + 2'd1;
      if (!found && elig[idx]) begin
        win_id = idx;
        found  = 1'b1;
      end
    end
  end
`else
  // Fixed priority pick: lowest eligible index wins
  always_comb begin
    win_id = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (elig[k]) win_id = 2'(k);
    end
  end
`endif

  // Next-state and next-output logic of the request/acknowledge sequencer
  always_comb begin
    state_d = state_q;
    nmi_d   = nmi_q;
    id_d    = id_q;
    act_d   = act_q;
    acc_d   = acc_q;
    pcnt_d  = pcnt_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    clr_vec = 4'b0000;
    set_to  = 1'b0;
`ifdef NMI_SRC_RR_PRIORITY_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if ((|elig) && ack_s) begin
          state_d = ASSERT;
          nmi_d   = 1'b1;
          id_d    = win_id;
          act_d   = 1'b1;
          acc_d   = 1'b0;
          pcnt_d  = PCW'(PULSE_CYCLES - 1);
          tcnt_d  = '0;
        end
      end
      ASSERT: begin
        tcnt_d = tcnt_q + TCW'(1);
        if (!ack_s) acc_d = 1'b1;
        if (pcnt_q == '0) begin
          nmi_d = 1'b0;
          if (acc_q || !ack_s) begin
            state_d      = IN_SERVICE;
            clr_vec[id_q] = 1'b1;
`ifdef NMI_SRC_RR_PRIORITY_EN
            last_d       = id_q;
`endif
          end else begin
            state_d = WAIT_ACCEPT;
          end
        end else begin
          pcnt_d = pcnt_q - PCW'(1);
        end
      end
      WAIT_ACCEPT: begin
        tcnt_d = tcnt_q + TCW'(1);
        if (!ack_s) begin
          state_d       = IN_SERVICE;
          clr_vec[id_q] = 1'b1;
`ifdef NMI_SRC_RR_PRIORITY_EN
          last_d        = id_q;
`endif
        end else if (tcnt_q >= TCW'(ACK_TIMEOUT - 1)) begin
          // CPU never accepted: flag it, keep the pending bit for a retry
          set_to  = 1'b1;
          act_d   = 1'b0;
          state_d = GAP;
          gcnt_d  = GCW'(GAP_CYCLES - 1);
        end
      end
      IN_SERVICE: begin
        if (ack_s) begin
          act_d   = 1'b0;
          state_d = GAP;
          gcnt_d  = GCW'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (gcnt_q == '0) state_d = IDLE;
        else              gcnt_d  = gcnt_q - GCW'(1);
      end
      default: state_d = IDLE;
    endcase
    // A new edge on a line being cleared must survive
    pend_d = (pend_q & ~clr_vec) | rise;
    terr_d = set_to | (terr_q & ~bus.clr_err);
  end

  // State, counters, edge detector and ack synchronizer (ack idles high)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      irq_q   <= '0;
      pend_q  <= '0;
      ack_m   <= 1'b1;
      ack_s   <= 1'b1;
      nmi_q   <= 1'b0;
      id_q    <= '0;
      act_q   <= 1'b0;
      terr_q  <= 1'b0;
      acc_q   <= 1'b0;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= bus.irq;
      pend_q  <= pend_d;
      ack_m   <= bus.nmi_ack;
      ack_s   <= ack_m;
      nmi_q   <= nmi_d;
      id_q    <= id_d;
      act_q   <= act_d;
      terr_q  <= terr_d;
      acc_q   <= acc_d;
      pcnt_q  <= pcnt_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

`ifdef NMI_SRC_RR_PRIORITY_EN
  // Last line that entered service; 3 so line 0 is searched first after reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= 2'd3;
    else        last_q <= last_d;
  end
`endif

  assign bus.nmi         = nmi_q;
  assign bus.nmi_id      = id_q;
  assign bus.pending     = pend_q;
  assign bus.active      = act_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_nmi_source_ctrl.sv
// Bench for nmi_source_ctrl: a CPU model answers each nmi, a reference model
// predicts the service order and pushes it into a queue, and a monitor checks
// every nmi pulse against the queue head.
module tb_nmi_source_ctrl;
  localparam int PULSE = 4;
  localparam int TO    = 64;
  localparam int GAP   = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  nmi_source_ctrl_if bus();

  nmi_source_ctrl #(.PULSE_CYCLES(PULSE), .ACK_TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct { int id; logic [3:0] pend; } exp_t;
  typedef struct { int id; bit ack; int dly; int svc; } cpu_t;

  exp_t       exp_q[$];
  cpu_t       cpu_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] model_pend = 4'b0000;
  int         model_last = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Which line the controller should serve from an eligible set
  function automatic int pick(input logic [3:0] elig);
    int start;
    start = 0;
`ifdef NMI_SRC_RR_PRIORITY_EN
    start = (model_last + 1) % 4;
`endif
    for (int k = 0; k < 4; k++)
      if (elig[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  // Predict every service until nothing eligible remains.
  // mode 0: CPU always accepts; 1: maybe one timeout; 2: first request times out
  task automatic plan(input logic [3:0] mask, input int mode);
    int   to_used;
    int   w;
    cpu_t c;
    to_used = 0;
    while ((model_pend & mask) != 4'b0000) begin
      w = pick(model_pend & mask);
      exp_q.push_back('{w, model_pend});
      c.id  = w;
      c.ack = 1'b1;
      if (to_used == 0 && ((mode == 1 && $urandom_range(0, 5) == 0) || mode == 2)) begin
        c.ack   = 1'b0;
        to_used = 1;
      end
      c.dly = $urandom_range(1, 20);
      c.svc = $urandom_range(2, 10);
      cpu_q.push_back(c);
      if (c.ack) begin
        model_pend[w] = 1'b0;
        model_last    = w;
      end
    end
  endtask

  task automatic pulse_irq(input logic [3:0] bits);
    bus.irq = bits;
    @(negedge clock);
    bus.irq = 4'b0000;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.active || bus.nmi) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("drain_in_time", n < 3000, 1);
    repeat (GAP + 4) @(negedge clock);
    check("idle_pending", bus.pending, model_pend);
    check("idle_timeout_err", bus.timeout_err, 0);
  endtask

  task automatic batch(input logic [3:0] bits, input logic [3:0] mask, input int mode);
    bus.irq_mask = 4'b0000;
    pulse_irq(bits);
    repeat (2) @(negedge clock);
    model_pend = model_pend | bits;
    check("latched_pending", bus.pending, model_pend);
    plan(mask, mode);
    bus.irq_mask = mask;
    drain();
  endtask

  task automatic wait_nmi();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.nmi && n < 200);
    check("nmi_seen", bus.nmi, 1);
  endtask

  // Monitor: every nmi rising edge consumes one expected service
  initial begin : monitor
    logic prev;
    int   width;
    exp_t e;
    prev  = 1'b0;
    width = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev  = 1'b0;
        width = 0;
      end else begin
        if (bus.nmi && !prev) begin
          check("nmi_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("nmi_id", bus.nmi_id, e.id);
            check("pending_at_nmi", bus.pending, e.pend);
            check("active_at_nmi", bus.active, 1);
          end
          width = 1;
        end else if (bus.nmi) begin
          width++;
        end else if (prev) begin
          check("pulse_width", width, PULSE);
        end
        prev = bus.nmi;
      end
    end
  end

  // CPU model: accept after a delay and return later, or never accept
  initial begin : cpu
    logic prev;
    cpu_t c;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && bus.nmi && !prev && cpu_q.size() != 0) begin
        c = cpu_q.pop_front();
        if (c.ack) begin
          repeat (c.dly) @(negedge clock);
          bus.nmi_ack = 1'b0;
          repeat (c.svc) @(negedge clock);
          bus.nmi_ack = 1'b1;
        end else begin
          repeat (TO - 1) @(negedge clock);
          check("timeout_err_early", bus.timeout_err, 0);
          @(negedge clock);
          check("timeout_err_set", bus.timeout_err, 1);
          check("active_after_timeout", bus.active, 0);
          check("pending_kept", bus.pending[c.id], 1);
          bus.clr_err = 1'b1;
          @(negedge clock);
          bus.clr_err = 1'b0;
          check("timeout_err_cleared", bus.timeout_err, 0);
        end
      end
      prev = bus.nmi;
    end
  end

  initial begin : stim
    bus.irq      = 4'b0000;
    bus.irq_mask = 4'b0000;
    bus.nmi_ack  = 1'b1;
    bus.clr_err  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_nmi", bus.nmi, 0);
    check("rst_nmi_id", bus.nmi_id, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_active", bus.active, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // single request, then two at once, then an unacknowledged one
    batch(4'b0100, 4'b1111, 0);
    batch(4'b1010, 4'b1111, 0);
    batch(4'b0001, 4'b1111, 2);

    // masked line latches but is not served until unmasked
    batch(4'b0001, 4'b1110, 0);
    check("masked_no_nmi", bus.nmi, 0);
    plan(4'b1111, 0);
    bus.irq_mask = 4'b1111;
    @(negedge clock);
    check("unmask_nmi", bus.nmi, 1);
    check("unmask_nmi_id", bus.nmi_id, 0);
    drain();

    // line 2 re-requests on the clear edge and again later in service
    bus.irq_mask = 4'b0000;
    pulse_irq(4'b0100);
    repeat (2) @(negedge clock);
    model_pend = model_pend | 4'b0100;
    exp_q.push_back('{2, model_pend});
    cpu_q.push_back('{2, 1'b1, 1, 12});
    exp_q.push_back('{2, model_pend});
    cpu_q.push_back('{2, 1'b1, 3, 5});
    model_pend[2] = 1'b0;
    model_last    = 2;
    bus.irq_mask  = 4'b0100;
    wait_nmi();
    repeat (3) @(negedge clock);
    bus.irq = 4'b0100;
    @(negedge clock);
    bus.irq = 4'b0000;
    check("rereq_pulse_over", bus.nmi, 0);
    check("rereq_same_edge", bus.pending[2], 1);
    repeat (3) @(negedge clock);
    pulse_irq(4'b0100);
    drain();

    // randomized batches
    repeat (25) batch(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), 1);

    // reset in the middle of a service
    begin
      int n;
      bus.irq_mask = 4'b0000;
      pulse_irq(4'b1010);
      repeat (2) @(negedge clock);
      model_pend = model_pend | 4'b1010;
      exp_q.push_back('{pick(model_pend & 4'b0010), model_pend});
      cpu_q.push_back('{1, 1'b1, 2, 60});
      bus.irq_mask = 4'b0010;
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!(bus.active && !bus.nmi && !bus.nmi_ack) && n < 200);
      repeat (3) @(negedge clock);
      check("in_service_before_reset", bus.active, 1);
      check("scoreboard_empty", exp_q.size(), 0);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_nmi", bus.nmi, 0);
      check("mid_rst_nmi_id", bus.nmi_id, 0);
      check("mid_rst_pending", bus.pending, 0);
      check("mid_rst_active", bus.active, 0);
      check("mid_rst_timeout_err", bus.timeout_err, 0);
      exp_q.delete();
      cpu_q.delete();
      model_pend = 4'b0000;
    end
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
